// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit.
// Byte-lane masks are little-endian: bit 0 is byte address offset 0.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    WB0  = 3'd2,
    ACC1 = 3'd3,
    WB1  = 3'd4,
    RESP = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_e;

  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  function automatic logic [3:0] lane_mask(input size_e s);
    logic [3:0] m;
    case (s)
      SZ_B:    m = LANE_B;
      SZ_H:    m = LANE_H;
      SZ_W:    m = LANE_W;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // True when the access runs past the end of its first word.
  function automatic logic is_split(input size_e s, input logic [1:0] off);
    logic r;
    case (s)
      SZ_H:    r = (off == 2'd3);
      SZ_W:    r = (off != 2'd0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane datapath: store merge into one word of a pair,
// and load extraction/extension from a (possibly split) word pair.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  size_e       i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_old_word,
  input  logic        i_hi_word,
  input  logic [31:0] i_ld_lo,
  input  logic [31:0] i_ld_hi,
  output logic [31:0] o_merged,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_bmask;
  logic [63:0] w_mask64;
  logic [63:0] w_sdata;
  logic [31:0] w_sel_mask;
  logic [31:0] w_sel_data;
  logic [31:0] w_ld;

  // Store path: shift data and lane mask across the 64-bit word pair, then pick a half.
  always_comb begin
    w_bmask  = {4'b0000, lane_mask(i_size)} << i_offset;
    w_mask64 = 64'd0;
    for (int i = 0; i < 8; i++) begin
      w_mask64[8*i +: 8] = {8{w_bmask[i]}};
    end
    w_sdata = {32'd0, i_wdata} << {i_offset, 3'b000};
    if (i_hi_word) begin
      w_sel_mask = w_mask64[63:32];
      w_sel_data = w_sdata[63:32];
    end else begin
      w_sel_mask = w_mask64[31:0];
      w_sel_data = w_sdata[31:0];
    end
    o_merged = (i_old_word & ~w_sel_mask) | (w_sel_data & w_sel_mask);
  end

  // Load path: right-align the addressed bytes, then extend.
  always_comb begin
    w_ld = 32'({i_ld_hi, i_ld_lo} >> {i_offset, 3'b000});
    case (i_size)
      SZ_B:    o_ld_data = i_unsigned ? {24'd0, w_ld[7:0]}  : {{24{w_ld[7]}}, w_ld[7:0]};
      SZ_H:    o_ld_data = i_unsigned ? {16'd0, w_ld[15:0]} : {{16{w_ld[15]}}, w_ld[15:0]};
      SZ_W:    o_ld_data = w_ld;
      default: o_ld_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit with byte/half/word access, misaligned split
// handling and read-modify-write for partial stores. All outputs registered.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        dm_rd_en,
  output logic        dm_wr_en,
  output logic [31:0] dm_address,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  state_e      r_state;
  logic [31:0] r_addr;
  size_e       r_size;
  logic        r_we;
  logic        r_uns;
  logic [31:0] r_wdata;
  logic [31:0] r_word0;
  logic        r_split;

  logic [31:0] w_idx0_in;
  logic [31:0] w_idx1_in;
  logic        w_split_in;
  logic        w_err_in;
  logic        w_full_word_in;
  logic [31:0] w_idx0;
  logic [31:0] w_idx1;
  logic        w_in_acc1;
  logic [31:0] w_ld_lo;
  logic [31:0] w_merged;
  logic [31:0] w_ld_data;

  // Request decode: range check covers the second word of a split access too.
  always_comb begin
    w_idx0_in      = {2'b00, req_addr[31:2]};
    w_idx1_in      = w_idx0_in + 32'd1;
    w_split_in     = is_split(size_e'(req_size), req_addr[1:0]);
    w_full_word_in = (req_size == SZ_W) && (req_addr[1:0] == 2'b00);
    if (req_size == SZ_ILL) begin
      w_err_in = 1'b1;
    end else begin
      w_err_in = ((w_idx0_in >> ADDR_W) != 32'd0) ||
                 (w_split_in && ((w_idx1_in >> ADDR_W) != 32'd0));
    end
  end

  assign w_idx0    = {2'b00, r_addr[31:2]};
  assign w_idx1    = w_idx0 + 32'd1;
  assign w_in_acc1 = (r_state == ACC1);
  assign w_ld_lo   = w_in_acc1 ? r_word0 : dm_rdata;

  lsu_byte_lane u_lane (
    .i_offset   (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata),
    .i_old_word (dm_rdata),
    .i_hi_word  (w_in_acc1),
    .i_ld_lo    (w_ld_lo),
    .i_ld_hi    (dm_rdata),
    .o_merged   (w_merged),
    .o_ld_data  (w_ld_data)
  );

  // Control FSM; every output is set for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= 32'd0;
      r_size     <= SZ_B;
      r_we       <= 1'b0;
      r_uns      <= 1'b0;
      r_wdata    <= 32'd0;
      r_word0    <= 32'd0;
      r_split    <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      dm_rd_en   <= 1'b0;
      dm_wr_en   <= 1'b0;
      dm_address <= 32'd0;
      dm_wdata   <= 32'd0;
    end else begin
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      dm_rd_en   <= 1'b0;
      dm_wr_en   <= 1'b0;
      dm_address <= 32'd0;
      dm_wdata   <= 32'd0;
      case (r_state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid) begin
            req_ready <= 1'b0;
            r_addr    <= req_addr;
            r_size    <= size_e'(req_size);
            r_we      <= req_we;
            r_uns     <= req_unsigned;
            r_wdata   <= req_wdata;
            r_split   <= w_split_in;
            if (w_err_in) begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_we && w_full_word_in) begin
              r_state    <= WB0;
              dm_wr_en   <= 1'b1;
              dm_address <= w_idx0_in;
              dm_wdata   <= req_wdata;
            end else begin
              r_state    <= ACC0;
              dm_rd_en   <= 1'b1;
              dm_address <= w_idx0_in;
            end
          end
        end
        ACC0: begin
          r_word0 <= dm_rdata;
          if (r_we) begin
            r_state    <= WB0;
            dm_wr_en   <= 1'b1;
            dm_address <= w_idx0;
            dm_wdata   <= w_merged;
          end else if (r_split) begin
            r_state    <= ACC1;
            dm_rd_en   <= 1'b1;
            dm_address <= w_idx1;
          end else begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= w_ld_data;
          end
        end
        WB0: begin
          if (r_split) begin
            r_state    <= ACC1;
            dm_rd_en   <= 1'b1;
            dm_address <= w_idx1;
          end else begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
          end
        end
        ACC1: begin
          if (r_we) begin
            r_state    <= WB1;
            dm_wr_en   <= 1'b1;
            dm_address <= w_idx1;
            dm_wdata   <= w_merged;
          end else begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= w_ld_data;
          end
        end
        WB1: begin
          r_state    <= RESP;
          resp_valid <= 1'b1;
        end
        RESP: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a behavioural data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        dm_rd_en;
  logic        dm_wr_en;
  logic [31:0] dm_address;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = 10'd0;
  logic [31:0] pl_data = 32'd0;

  int cyc = 0;
  int passed = 0;
  int total = 0;
  int fails = 0;
  bit overlap_seen = 1'b0;
  bit stray_rdata = 1'b0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;
  exp_t sbq[$];

  load_store_unit #(.ADDR_W(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .dm_rd_en     (dm_rd_en),
    .dm_wr_en     (dm_wr_en),
    .dm_address   (dm_address),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign dm_rdata = (dm_address < 32'd1024) ? mem[dm_address[9:0]] : 32'd0;

  always @(posedge clk) begin
    if (dm_wr_en && dm_address < 32'd1024) mem[dm_address[9:0]] <= dm_wdata;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  always @(negedge clk) begin
    if (dm_rd_en && dm_wr_en) overlap_seen <= 1'b1;
    if (!resp_valid && resp_rdata != 32'd0) stray_rdata <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Drives one request and returns the cycle index of the accepting cycle.
  task automatic do_accept(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd, output int acc);
    int guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    acc = cyc - 1;
    req_valid = 1'b0; req_wdata = 32'hA5A5_A5A5; req_addr = 32'hFFFF_FFFF;
  endtask

  task automatic issue(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd, input int e_lat,
                       input int e_nrd, input int e_nwr);
    exp_t e;
    int acc;
    int nrd = 0;
    int nwr = 0;
    bit got = 1'b0;
    e.err = e_err; e.rdata = e_rd; e.lat = e_lat; e.nrd = e_nrd; e.nwr = e_nwr;
    sbq.push_back(e);
    do_accept(we, sz, uns, addr, wd, acc);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (dm_rd_en) nrd++;
      if (dm_wr_en) nwr++;
      if (resp_valid) begin
        got = 1'b1;
        e = sbq.pop_front();
        chk({tag, " lat"},   32'(cyc - acc), 32'(e.lat));
        chk({tag, " err"},   {31'd0, resp_err}, {31'd0, e.err});
        chk({tag, " rdata"}, resp_rdata, e.rdata);
        chk({tag, " nrd"},   32'(nrd), 32'(e.nrd));
        chk({tag, " nwr"},   32'(nwr), 32'(e.nwr));
      end
    end
    if (!got) begin
      void'(sbq.pop_front());
      chk({tag, " timeout"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    int acc;
    bit rv_seen;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst ready", {31'd0, req_ready}, 32'd1);
    chk("rst resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("rst rdata", resp_rdata, 32'd0);
    chk("rst dm en", {30'd0, dm_rd_en, dm_wr_en}, 32'd0);
    chk("rst dm addr", dm_address, 32'd0);
    chk("rst dm wdata", dm_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    poke(10'd4, 32'h1122_3344);
    issue("lw 0x10", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, 32'h1122_3344, 2, 1, 0);

    poke(10'd4, 32'h80FF_7F01);
    issue("lb 0x13",  1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 1'b0, 32'hFFFF_FF80, 2, 1, 0);
    issue("lbu 0x13", 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 1'b0, 32'h0000_0080, 2, 1, 0);
    issue("lh 0x10",  1'b0, 2'b01, 1'b0, 32'h10, 32'd0, 1'b0, 32'h0000_7F01, 2, 1, 0);
    issue("lh 0x12",  1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 1'b0, 32'hFFFF_80FF, 2, 1, 0);
    issue("lhu 0x12", 1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 1'b0, 32'h0000_80FF, 2, 1, 0);

    poke(10'd4, 32'h1122_3344);
    poke(10'd5, 32'h5566_7788);
    issue("lw 0x11 split", 1'b0, 2'b10, 1'b0, 32'h11, 32'd0, 1'b0, 32'h8811_2233, 3, 2, 0);
    issue("lh 0x13 split", 1'b0, 2'b01, 1'b0, 32'h13, 32'd0, 1'b0, 32'hFFFF_8811, 3, 2, 0);

    issue("sb 0x11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 1'b0, 32'd0, 3, 1, 1);
    chk("sb word4", mem[4], 32'h1122_AB44);

    poke(10'd4, 32'd0);
    poke(10'd5, 32'd0);
    issue("sw 0x12 split", 1'b1, 2'b10, 1'b0, 32'h12, 32'hDEAD_BEEF, 1'b0, 32'd0, 5, 2, 2);
    chk("sw split word4", mem[4], 32'hBEEF_0000);
    chk("sw split word5", mem[5], 32'h0000_DEAD);

    issue("sh 0x16", 1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF_1234, 1'b0, 32'd0, 3, 1, 1);
    chk("sh word5", mem[5], 32'h1234_DEAD);

    issue("sw 0x20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b0, 32'd0, 2, 0, 1);
    chk("sw word8", mem[8], 32'hCAFE_F00D);

    poke(10'h3FF, 32'h0BAD_F00D);
    issue("lw 0xFFC edge", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'd0, 1'b0, 32'h0BAD_F00D, 2, 1, 0);
    issue("lw 0xFFE oor",  1'b0, 2'b10, 1'b0, 32'hFFE, 32'd0, 1'b1, 32'd0, 1, 0, 0);
    issue("lb 0x1000 oor", 1'b0, 2'b00, 1'b0, 32'h1000, 32'd0, 1'b1, 32'd0, 1, 0, 0);
    issue("ld size11",     1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 1'b1, 32'd0, 1, 0, 0);
    issue("st size11",     1'b1, 2'b11, 1'b0, 32'h20, 32'h1234_5678, 1'b1, 32'd0, 1, 0, 0);
    chk("st size11 word8", mem[8], 32'hCAFE_F00D);

    // Abandon a split load while the second word is being read.
    poke(10'd4, 32'h1122_3344);
    poke(10'd5, 32'h5566_7788);
    do_accept(1'b0, 2'b10, 1'b0, 32'h11, 32'd0, acc);
    @(negedge clk);
    @(negedge clk);
    chk("mid ACC1 addr", {dm_address[30:0], dm_rd_en}, {31'd5, 1'b1});
    reset = 1'b1;
    @(negedge clk);
    chk("mid rst ready", {31'd0, req_ready}, 32'd1);
    chk("mid rst resp", {31'd0, resp_valid}, 32'd0);
    reset = 1'b0;
    rv_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) rv_seen = 1'b1;
    end
    chk("mid rst no resp", {31'd0, rv_seen}, 32'd0);
    chk("sb queue empty", 32'(sbq.size()), 32'd0);
    chk("rd/wr overlap", {31'd0, overlap_seen}, 32'd0);
    chk("stray rdata", {31'd0, stray_rdata}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
